// File: rtl/cpu_pkg.sv
// Shared CPU register-file types and sizes.
// Pure declarations: no logic, no latency, no flow control.
package cpu_pkg;
  localparam int REG_DW    = 32;
  localparam int REG_AW    = 5;
  localparam int REG_COUNT = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/dffe_clr_w.sv
// DW-bit enabled register with asynchronous active-high clear; loads d on the clock edge when en=1.
// Latency one edge; no backpressure, en is the only load qualifier and clr overrides it.
module dffe_clr_w
  import cpu_pkg::*;
#(
  parameter int DW = REG_DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file, R0 hardwired to zero; write lands one edge later, reads are combinational.
// No backpressure; REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          We,
  input  logic [AW-1:0] Wa,
  input  logic [DW-1:0] Wd,
  input  logic [AW-1:0] Ra1,
  output logic [DW-1:0] Rd1,
  input  logic [AW-1:0] Ra2,
  output logic [DW-1:0] Rd2
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:1] wsel;
  logic [DW-1:0]    q [DEPTH];
  logic [DW-1:0]    rd1_mem;
  logic [DW-1:0]    rd2_mem;

  // R0 has no storage; the mux sees a constant zero in its slot.
  assign q[0] = '0;

  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_reg
      assign wsel[i] = We & (Wa == AW'(i));

      dffe_clr_w #(
        .DW (DW)
      ) u_reg (
        .clk (Clk),
        .clr (Clr),
        .en  (wsel[i]),
        .d   (Wd),
        .q   (q[i])
      );
    end
  endgenerate

  assign rd1_mem = q[Ra1];
  assign rd2_mem = q[Ra2];

`ifdef REGFILE_BYPASS_EN
  logic wr_live;

  // Bypass is masked by Clr so the outputs stay zero throughout reset.
  assign wr_live = We & (Wa != AW'(REG_ZERO)) & ~Clr;
  assign Rd1     = (wr_live && (Ra1 == Wa)) ? Wd : rd1_mem;
  assign Rd2     = (wr_live && (Ra2 == Wa)) ? Wd : rd2_mem;
`else
  assign Rd1 = rd1_mem;
  assign Rd2 = rd2_mem;
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_2r1w;
  logic        Clk;
  logic        Clr;
  logic        We;
  logic [4:0]  Wa;
  logic [31:0] Wd;
  logic [4:0]  Ra1;
  logic [31:0] Rd1;
  logic [4:0]  Ra2;
  logic [31:0] Rd2;

  int checks;
  int errors;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_2r1w #(
    .DW (32),
    .AW (5)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .We  (We),
    .Wa  (Wa),
    .Wd  (Wd),
    .Ra1 (Ra1),
    .Rd1 (Rd1),
    .Ra2 (Ra2),
    .Rd2 (Rd2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge Clk);
    We = 1'b1;
    Wa = a;
    Wd = d;
    @(posedge Clk);
    #1;
    We = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Clr = 1'b0;
    We  = 1'b0;
    Wa  = '0;
    Wd  = '0;
    Ra1 = 5'd3;
    Ra2 = 5'd31;
    #1 Clr = 1'b1;
    #1;
    check("reset_rd1", Rd1, 32'h0);
    check("reset_rd2", Rd2, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Clr = 1'b0;

    // Basic write/read on both ports
    wr(5'd7, 32'h12345678);
    wr(5'd31, 32'hFFFFFFFF);
    Ra1 = 5'd7;
    Ra2 = 5'd31;
    #1;
    check("rd1_r7", Rd1, 32'h12345678);
    check("rd2_r31", Rd2, 32'hFFFFFFFF);
    Ra2 = 5'd7;
    #1;
    check("same_addr_rd2", Rd2, 32'h12345678);

    // Writes to R0 are dropped
    wr(5'd0, 32'hA5A5A5A5);
    Ra1 = 5'd0;
    Ra2 = 5'd0;
    #1;
    check("r0_rd1", Rd1, 32'h0);
    check("r0_rd2", Rd2, 32'h0);
    Ra1 = 5'd7;
    Ra2 = 5'd31;
    #1;
    check("r0_no_side_r7", Rd1, 32'h12345678);
    check("r0_no_side_r31", Rd2, 32'hFFFFFFFF);

    // Same-cycle write and read of R3
    wr(5'd3, 32'h11);
    @(negedge Clk);
    We  = 1'b1;
    Wa  = 5'd3;
    Wd  = 32'h22;
    Ra1 = 5'd3;
    Ra2 = 5'd7;
    #1;
    check("raw_before_edge", Rd1, BYPASS ? 32'h22 : 32'h11);
    check("raw_other_port", Rd2, 32'h12345678);
    @(posedge Clk);
    #1;
    We = 1'b0;
    check("raw_after_edge", Rd1, 32'h22);

    // Write to R0 with a read of R0 must never forward
    @(negedge Clk);
    We  = 1'b1;
    Wa  = 5'd0;
    Wd  = 32'hFFFF0000;
    Ra1 = 5'd0;
    #1;
    check("r0_no_forward", Rd1, 32'h0);
    @(posedge Clk);
    #1;
    We = 1'b0;

    // We=0 holds contents over several edges
    @(negedge Clk);
    Wa  = 5'd9;
    Wd  = 32'hCAFEBABE;
    Ra1 = 5'd9;
    repeat (3) @(posedge Clk);
    #1;
    check("we0_hold_r9", Rd1, 32'h0);

    // Asynchronous clear mid-cycle, colliding with a write
    wr(5'd5, 32'hDEADBEEF);
    Ra1 = 5'd5;
    #1;
    check("r5_before_clr", Rd1, 32'hDEADBEEF);
    @(negedge Clk);
    #2;
    Clr = 1'b1;
    #1;
    check("clr_async_r5", Rd1, 32'h0);
    We  = 1'b1;
    Wa  = 5'd4;
    Wd  = 32'h55;
    Ra2 = 5'd4;
    #1;
    check("clr_write_rd2", Rd2, 32'h0);
    @(posedge Clk);
    #1;
    check("clr_edge_rd2", Rd2, 32'h0);
    @(negedge Clk);
    We  = 1'b0;
    Clr = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      Ra1 = 5'(a);
      Ra2 = 5'(31 - a);
      #1;
      check($sformatf("post_clr_rd1_r%0d", a), Rd1, 32'h0);
      check($sformatf("post_clr_rd2_r%0d", 31 - a), Rd2, 32'h0);
    end

    // First write after release takes effect on the first edge
    wr(5'd6, 32'h0BADF00D);
    Ra1 = 5'd6;
    #1;
    check("first_wr_after_clr", Rd1, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

CPU general-purpose register file: 32 registers × 32 bits, one synchronous write port and two asynchronous read ports. Instruction decode reads the operands through the read ports, and writeback writes the result through the write port. The destination address comes from the pipeline's 5-bit enabled address register. Register 0 is hardwired to zero.

## Interface
Parameters:
- DW, 32, data width per register
- AW, 5, address width; depth is 2^AW

Ports:
- Clk  in  1  rising-edge clock
- Clr  in  1  asynchronous active-high reset; clears all registers
- We  in  1  write enable
- Wa  in  AW  write address
- Wd  in  DW  write data
- Ra1  in  AW  read address, port 1
- Rd1  out  DW  read data, port 1
- Ra2  in  AW  read address, port 2
- Rd2  out  DW  read data, port 2

## Operation
- Storage: registers R1..R(2^AW−1) are each DW-bit flops with an enable and an asynchronous clear. R0 has no storage.
- Write: on a Clk rising edge with We=1 and Wa≠0, the register at Wa takes Wd.
  - We=1 with Wa=0 is legal and has no effect.
  - We=0 leaves every register unchanged.
- Read: Rd1 and Rd2 are combinational functions of Ra1/Ra2 and the current storage.
  - Ra=0 always returns 0.
  - Both ports may address the same register; both then return the same value.
- Reset: when Clr is asserted, every register goes to 0 immediately, with no dependence on Clk. While Clr is high, Rd1=Rd2=0 for any address, and writes are ignored.
- Clr deassertion: the first write can occur on the first Clk edge at which Clr is already low.
- Width rules: Wd is stored without modification. Out-of-range addresses cannot occur because depth is exactly 2^AW.

## Timing
- Write latency: 1 edge. Data presented at edge N becomes readable after edge N.
- Read latency: 0 cycles (combinational path from address to data).
- Same-cycle write and read of the same address (Ra==Wa, We=1, Wa≠0):
  - Without bypass: the read returns the old value until the edge.
  - With bypass: see Configuration.
- Reset outputs: Rd1=0 and Rd2=0 while Clr is high. All registers read 0 after reset until they are written.
- Clr asserted in the same cycle as a write: reset wins, and the register stays 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding is active.
  - If We=1, Wa≠0 and Ra1==Wa, then Rd1=Wd in the same cycle. Rd2 behaves the same way with Ra2.
  - Ra=0 still returns 0.
  - During Clr, the outputs remain 0.
- REGFILE_BYPASS_EN undefined:
  - No forwarding. Reads always reflect stored contents.
  - The pipeline must stall or forward externally.

## Structure
- Shared package `cpu_pkg`:
  - REG_DW=32, REG_AW=5, REG_COUNT=32
  - REG_ZERO address constant (0)
  - reg_addr_t and reg_data_t typedefs
- One sub-module, `dffe_clr_w`: a DW-bit enabled register with asynchronous active-high clear. It is instantiated 2^AW−1 times through a generate loop, and each instance's enable is We & (Wa==i).
- A 5-to-32 write-address decoder and two 32:1 read multiplexers sit in the top module.

## Test plan
- Reset check: assert Clr mid-run after writing R5=0xDEADBEEF → Rd1 at Ra1=5 reads 0 immediately, without any clock edge. After release, every address reads 0.
- Basic write/read: write R7=0x12345678, then R31=0xFFFFFFFF → on the next cycle, Ra1=7 gives 0x12345678 and Ra2=31 gives 0xFFFFFFFF simultaneously.
- Register 0: write Wa=0, Wd=0xA5A5A5A5 → Ra1=Ra2=0 read 0. No other register changes.
- Same-cycle read of the write target: R3 holds 0x11, then We=1, Wa=3, Wd=0x22 with Ra1=3 before the edge.
  - With REGFILE_BYPASS_EN: Rd1=0x22 before the edge.
  - Without it: Rd1=0x11 before the edge and 0x22 after.
- We=0 hold: drive Wa=9, Wd=0xCAFEBABE with We=0 for 3 edges → R9 keeps its prior value 0x0.
- Reset vs write collision: Clr=1 with We=1, Wa=4, Wd=0x55 across an edge → R4 reads 0 after Clr drops.
